// File: rtl/load_extend_ctrl.sv
// load_extend_ctrl
//   Load sequencer for the KGP-RISC load path. Takes one load request from
//   the core, performs a word-aligned read handshake with data memory,
//   selects the addressed byte/halfword lane (little-endian), sign- or
//   zero-extends it to 32 bits and returns it with a one-cycle valid pulse.
//   Misaligned/illegal requests and reads that wait too long for mem_ack
//   return an error pulse instead.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   req_valid  load request strobe (sampled only when idle)
//   req_addr   byte address
//   req_size   00 byte, 01 halfword, 10 word, 11 illegal
//   req_signed 1 sign-extend, 0 zero-extend (ignored for word)
//   busy       high while a load is in flight (core stalls)
//   mem_re     memory read request, held until mem_ack
//   mem_addr   word-aligned read address
//   mem_rdata  read data, valid when mem_ack is high
//   mem_ack    read complete
//   ld_valid   one-cycle result pulse
//   ld_data    extended result (0 on error), held until the next result
//   ld_err     qualifies ld_valid: the access faulted
//
// Parameters
//   TIMEOUT    cycles mem_re may wait for mem_ack before aborting (1..255)

module load_extend_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        busy,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        ld_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Counter value at which one more ack-less REQ cycle hits TIMEOUT.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  to_cnt;
    logic [1:0]  addr_lo;
    logic [1:0]  size_q;
    logic        signed_q;

    logic        req_fault;
    logic [31:0] ext_data;

    // Alignment check on the live request, evaluated only when accepting.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        req_fault = 1'b0;
        case (req_size)
            SZ_BYTE: req_fault = 1'b0;
            SZ_HALF: req_fault = req_addr[0];
            SZ_WORD: req_fault = |req_addr[1:0];
            default: req_fault = 1'b1;
        endcase
    end

    // Lane select and extension of the returning read word.
    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b   = 8'h00;
        lane_h   = 16'h0000;
        ext_data = mem_rdata;
        case (addr_lo)
            2'd0:    lane_b = mem_rdata[7:0];
            2'd1:    lane_b = mem_rdata[15:8];
            2'd2:    lane_b = mem_rdata[23:16];
            default: lane_b = mem_rdata[31:24];
        endcase
        lane_h = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            SZ_BYTE: ext_data = {{24{signed_q & lane_b[7]}}, lane_b};
            SZ_HALF: ext_data = {{16{signed_q & lane_h[15]}}, lane_h};
            default: ext_data = mem_rdata;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            mem_re   <= 1'b0;
            mem_addr <= 32'h0000_0000;
            ld_valid <= 1'b0;
            ld_err   <= 1'b0;
            ld_data  <= 32'h0000_0000;
            to_cnt   <= 8'd0;
            addr_lo  <= 2'b00;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
        end else begin
            // Result flags are pulses: cleared unless set on the transition below.
            ld_valid <= 1'b0;
            ld_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_lo  <= req_addr[1:0];
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        busy     <= 1'b1;
                        if (req_fault) begin
                            state    <= S_ERR;
                            ld_valid <= 1'b1;
                            ld_err   <= 1'b1;
                            ld_data  <= 32'h0000_0000;
                        end else begin
                            state    <= S_REQ;
                            mem_re   <= 1'b1;
                            mem_addr <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                S_REQ: begin
                    // An ack in the timeout cycle still completes normally.
                    if (mem_ack) begin
                        state    <= S_RESP;
                        mem_re   <= 1'b0;
                        to_cnt   <= 8'd0;
                        ld_valid <= 1'b1;
                        ld_data  <= ext_data;
                    end else if (to_cnt == TO_LAST) begin
                        state    <= S_ERR;
                        mem_re   <= 1'b0;
                        to_cnt   <= 8'd0;
                        ld_valid <= 1'b1;
                        ld_err   <= 1'b1;
                        ld_data  <= 32'h0000_0000;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                default: begin
                    // RESP and ERR last one cycle while the pulse is visible.
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_extend_ctrl.sv
// Testbench for load_extend_ctrl: directed loads against a small memory
// responder; expected results go into a scoreboard queue and a separate
// monitor compares them whenever ld_valid is presented.

module tb_load_extend_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic        busy;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_err;

    load_extend_ctrl #(.TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .busy       (busy),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_err     (ld_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t sb[$];

    // Memory responder: acks after ack_delay extra mem_re cycles.
    int          ack_delay = 0;
    int          re_cycles = 0;
    logic [31:0] exp_maddr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h8001_936E;
            32'h0000_0200: return 32'h2D15_0000;
            32'h0000_0204: return 32'h2D15_0000;
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(negedge clk) begin
        if (mem_re) begin
            if (re_cycles == 0) check("mem_addr", mem_addr, exp_maddr);
            if (re_cycles == ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'h5A5A_5A5A;
            end
            re_cycles++;
        end else begin
            mem_ack = 1'b0;
        end
    end

    // Monitor: every ld_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (ld_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_ld_valid", 32'(ld_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ld_data", ld_data, e.data);
                check("ld_err", 32'(ld_err), 32'(e.err));
                check("ld_latency", cyc, e.due);
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        check("drain_timeout", sb.size(), 0);
        sb.delete();
        @(negedge clk);
    endtask

    // One load: lat is cycles from accept to ld_valid, exp_re the number of
    // mem_re-high cycles the access should produce.
    task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                           input int k, input logic [31:0] exp_d, input logic exp_e,
                           input int lat, input int exp_re);
        exp_t e;
        @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        exp_maddr  = {addr[31:2], 2'b00};
        ack_delay  = k;
        re_cycles  = 0;
        e.data = exp_d;
        e.err  = exp_e;
        e.due  = cyc + lat;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_drain();
        check("mem_re_cycles", re_cycles, exp_re);
        check("busy_idle", 32'(busy), 32'd0);
        if (!exp_e) check("ld_data_hold", ld_data, exp_d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_ld_valid", 32'(ld_valid), 32'd0);
        check("rst_ld_err", 32'(ld_err), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_ld_data", ld_data, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Sub-word and word loads from 0x100 = 0x8001936E.
        do_load(32'h101, 2'b00, 1'b1, 2, 32'hFFFF_FF93, 1'b0, 4, 3);
        do_load(32'h100, 2'b00, 1'b1, 0, 32'h0000_006E, 1'b0, 2, 1);
        do_load(32'h100, 2'b01, 1'b1, 0, 32'hFFFF_936E, 1'b0, 2, 1);
        do_load(32'h100, 2'b01, 1'b0, 0, 32'h0000_936E, 1'b0, 2, 1);
        do_load(32'h102, 2'b01, 1'b1, 0, 32'hFFFF_8001, 1'b0, 2, 1);
        do_load(32'h101, 2'b00, 1'b0, 1, 32'h0000_0093, 1'b0, 3, 2);
        do_load(32'h100, 2'b10, 1'b1, 0, 32'h8001_936E, 1'b0, 2, 1);

        // Faults: no memory access, error pulse one cycle after accept.
        do_load(32'h101, 2'b01, 1'b0, 0, 32'h0, 1'b1, 1, 0);
        do_load(32'h102, 2'b10, 1'b0, 0, 32'h0, 1'b1, 1, 0);
        do_load(32'h100, 2'b11, 1'b0, 0, 32'h0, 1'b1, 1, 0);

        // Timeout: no ack ever, then ack on the 15th mem_re cycle.
        do_load(32'h100, 2'b10, 1'b0, 1000, 32'h0, 1'b1, 16, 15);
        do_load(32'h103, 2'b00, 1'b0, 14, 32'h0000_0080, 1'b0, 16, 15);

        // req_valid held high: second load accepted in the IDLE cycle after
        // the first ld_valid, so accept cycles are c and c+3.
        @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = 32'h200;
        req_size   = 2'b10;
        req_signed = 1'b1;
        exp_maddr  = 32'h200;
        ack_delay  = 0;
        re_cycles  = 0;
        e.data = 32'h2D15_0000; e.err = 1'b0; e.due = cyc + 2;
        sb.push_back(e);
        e.due = cyc + 5;
        sb.push_back(e);
        @(negedge clk);
        req_addr = 32'h204;
        @(negedge clk);
        @(negedge clk);
        exp_maddr = 32'h204;
        re_cycles = 0;
        @(negedge clk);
        req_valid = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
        check("b2b_second_re_cycles", re_cycles, 1);

        // Reset in the middle of REQ aborts without a result.
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h100;
        req_size  = 2'b10;
        exp_maddr = 32'h100;
        ack_delay = 1000;
        re_cycles = 0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_mem_re", 32'(mem_re), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_mem_re", 32'(mem_re), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        do_load(32'h102, 2'b01, 1'b0, 0, 32'h0000_8001, 1'b0, 2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
